// File: rtl/toggle_bank_arbiter_if.sv
// rtl/toggle_bank_arbiter_if.sv - requester handshake bundle for the toggle bank arbiter
interface toggle_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_mask;
    logic [NREQ-1:0]   req_ready;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;

    modport master (
        output req_valid,
        output req_mask,
        input  req_ready,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req_valid,
        input  req_mask,
        output req_ready,
        output grant_valid,
        output grant_id
    );
endinterface

// File: rtl/toggle_bank_arbiter.sv
// rtl/toggle_bank_arbiter.sv - round-robin arbiter sharing one toggle flip-flop bank
module toggle_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    toggle_bank_arbiter_if.slave  bus,
    output logic [W-1:0]          q,
    output logic [15:0]           toggle_count
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic            found;
    logic            grant;
    logic [NREQ-1:0] ready;
    logic [W-1:0]    sel_mask;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    assign grant = found && !freeze;

    always_comb begin
        ready = '0;
        if (grant) ready[winner] = 1'b1;
    end

    assign sel_mask        = bus.req_mask[int'(winner)*W +: W];
    assign bus.req_ready   = ready;
    assign bus.grant_valid = grant;
    assign bus.grant_id    = grant ? winner : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            q            <= '0;
            toggle_count <= '0;
        end else if (grant) begin
            q      <= q ^ sel_mask;
            rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
            if (toggle_count != 16'hFFFF) toggle_count <= toggle_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// tb/tb_toggle_bank_arbiter.sv - directed vector bench for toggle_bank_arbiter
module tb_toggle_bank_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze = 1'b0;
    logic [7:0]  q;
    logic [15:0] toggle_count;

    int total = 0;
    int bad   = 0;

    toggle_bank_arbiter_if #(.NREQ(4), .W(8)) bus ();

    toggle_bank_arbiter #(.NREQ(4), .W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .bus          (bus),
        .q            (q),
        .toggle_count (toggle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] mask;
        logic        frz;
        logic [3:0]  ready;
        logic [1:0]  gid;
        logic [7:0]  q;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_comb(input string tag, input logic [3:0] r, input logic [1:0] g);
        chk({tag, " ready"}, 32'(bus.req_ready), 32'(r));
        chk({tag, " grant_valid"}, 32'(bus.grant_valid), 32'(|r));
        chk({tag, " grant_id"}, 32'(bus.grant_id), 32'(g));
    endtask

    task automatic check_regs(input string tag, input logic [7:0] eq, input logic [15:0] ec);
        chk({tag, " q"}, 32'(q), 32'(eq));
        chk({tag, " count"}, 32'(toggle_count), 32'(ec));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_mask  = '0;

        // Full contention from reset pointer 0, one distinct bit per requester.
        vecs[0]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0001, 2'd0, 8'h01, 16'd1};
        vecs[1]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0010, 2'd1, 8'h03, 16'd2};
        vecs[2]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0100, 2'd2, 8'h07, 16'd3};
        vecs[3]  = '{4'b1111, 32'h08040201, 1'b0, 4'b1000, 2'd3, 8'h0F, 16'd4};
        vecs[4]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0001, 2'd0, 8'h0E, 16'd5};
        vecs[5]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0010, 2'd1, 8'h0C, 16'd6};
        vecs[6]  = '{4'b1111, 32'h08040201, 1'b0, 4'b0100, 2'd2, 8'h08, 16'd7};
        vecs[7]  = '{4'b1111, 32'h08040201, 1'b0, 4'b1000, 2'd3, 8'h00, 16'd8};
        vecs[8]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 2'd2, 8'hA5, 16'd9};
        vecs[9]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 2'd2, 8'h00, 16'd10};
        vecs[10] = '{4'b1001, 32'h08040201, 1'b0, 4'b1000, 2'd3, 8'h08, 16'd11};
        vecs[11] = '{4'b0001, 32'h08040201, 1'b0, 4'b0001, 2'd0, 8'h09, 16'd12};
        vecs[12] = '{4'b1111, 32'h08040201, 1'b1, 4'b0000, 2'd0, 8'h09, 16'd12};
        vecs[13] = '{4'b1111, 32'h08040201, 1'b1, 4'b0000, 2'd0, 8'h09, 16'd12};
        vecs[14] = '{4'b1111, 32'h08040201, 1'b1, 4'b0000, 2'd0, 8'h09, 16'd12};
        vecs[15] = '{4'b1111, 32'h08040201, 1'b0, 4'b0010, 2'd1, 8'h0B, 16'd13};
        vecs[16] = '{4'b0000, 32'h08040201, 1'b0, 4'b0000, 2'd0, 8'h0B, 16'd13};
        vecs[17] = '{4'b0010, 32'h08040201, 1'b0, 4'b0010, 2'd1, 8'h09, 16'd14};

        #12 rst = 1'b0;
        #1;
        check_regs("reset", 8'h00, 16'd0);
        check_comb("reset", 4'b0000, 2'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            bus.req_valid = vecs[i].valid;
            bus.req_mask  = vecs[i].mask;
            freeze        = vecs[i].frz;
            #1;
            check_comb($sformatf("vec%0d", i), vecs[i].ready, vecs[i].gid);
            @(posedge clk); #1;
            check_regs($sformatf("vec%0d", i), vecs[i].q, vecs[i].cnt);
        end

        // Transfer in flight when reset asserts mid-cycle is lost.
        bus.req_valid = 4'b0001;
        bus.req_mask  = 32'h000000FF;
        #2 rst = 1'b1;
        #1;
        check_regs("async rst", 8'h00, 16'd0);
        @(posedge clk); #1;
        check_regs("rst held", 8'h00, 16'd0);
        bus.req_valid = '0;
        #1;
        check_comb("rst idle", 4'b0000, 2'd0);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_regs("idle 10", 8'h00, 16'd0);
        check_comb("idle 10", 4'b0000, 2'd0);

        // Saturation: 65535 transfers of mask 01 leaves q=01.
        bus.req_valid = 4'b0001;
        bus.req_mask  = 32'h00000001;
        repeat (65535) @(posedge clk);
        #1;
        check_regs("sat", 8'h01, 16'hFFFF);
        check_comb("sat", 4'b0001, 2'd0);
        @(posedge clk); #1;
        check_regs("sat hold", 8'h00, 16'hFFFF);

        // Zero-mask transfer: q holds but the pointer still advances.
        bus.req_valid = 4'b0011;
        bus.req_mask  = 32'h00000000;
        #1;
        check_comb("zero1", 4'b0010, 2'd1);
        @(posedge clk); #1;
        check_regs("zero1", 8'h00, 16'hFFFF);
        check_comb("zero2", 4'b0001, 2'd0);
        @(posedge clk); #1;
        check_regs("zero2", 8'h00, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
